// File: rtl/bram_wr_sched_pkg.sv
// Shared definitions for the L1 BRAM write-port scheduler: FSM state type,
// starvation counter width and the byte-strobe width helper.
package l1_cache_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } wr_state_e;

    localparam int STARVE_W = 4;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/bram_wr_sched_if.sv
// Request/BRAM-write bundle between L1 control (master) and the write-port
// scheduler (slave).
interface bram_wr_sched_if
    import l1_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    localparam int STRB_W = strb_width(DATA_WIDTH);

    logic                  rf_valid;
    logic                  rf_ready;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data;

    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic [STRB_W-1:0]     st_strb;

    logic [ADDR_WIDTH-1:0] bram_waddr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [STRB_W-1:0]     bram_we;
    logic                  init_done;

    modport master (
        output rf_valid, rf_addr, rf_data,
        output st_valid, st_addr, st_data, st_strb,
        input  rf_ready, st_ready,
        input  bram_waddr, bram_din, bram_we, init_done
    );

    modport slave (
        input  rf_valid, rf_addr, rf_data,
        input  st_valid, st_addr, st_data, st_strb,
        output rf_ready, st_ready,
        output bram_waddr, bram_din, bram_we, init_done
    );

endinterface

// File: rtl/bram_wr_sched_arb.sv
// Combinational refill/store priority arbiter: refill wins unless a waiting
// store has already been passed over STARVE_LIMIT times.
module bram_wr_prio_arb
    import l1_cache_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                run_i,
    input  logic                rf_valid_i,
    input  logic                st_valid_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output logic                rf_ready_o,
    output logic                st_ready_o,
    output logic                rf_grant_o,
    output logic                st_grant_o
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    // Readies never look at the requester's own valid; the two conditions are
    // mutually exclusive whenever both valids are high.
    always_comb begin
        rf_ready_o = run_i && (!st_valid_i || (starve_cnt_i < LIMIT));
        st_ready_o = run_i && (!rf_valid_i || (starve_cnt_i == LIMIT));
        rf_grant_o = rf_valid_i && rf_ready_o;
        st_grant_o = st_valid_i && st_ready_o;
    end

endmodule

// File: rtl/bram_wr_sched.sv
// BRAM write-port scheduler: arbitrates refill and store writes onto one
// registered byte-write port. Define L1_BRAM_CLEAR_EN to zero-sweep the array after reset.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_CLEAR | zero sweep in progress, requests held off
// ST_RUN   | normal arbitration, init_done high
module bram_wr_sched
    import l1_cache_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rstn,
    bram_wr_sched_if.slave   bus
);

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam logic [STRB_W-1:0]   WE_ALL     = '1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    logic                  run;
    logic                  rf_ready;
    logic                  st_ready;
    logic                  rf_grant;
    logic                  st_grant;

    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [STRB_W-1:0]     we_q, we_d;

`ifdef L1_BRAM_CLEAR_EN
    localparam logic [0:0]            S_CLEAR  = ST_CLEAR;
    localparam logic [0:0]            S_RUN    = ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clearing;

    assign clearing = (state_q == S_CLEAR);
    assign run      = (state_q == S_RUN);

    // The counter wraps back to 0 on the last address, so no extra write follows.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (clearing) begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == CLR_LAST) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign bus.init_done = run;
`else
    assign run           = 1'b1;
    assign bus.init_done = 1'b1;
`endif

    bram_wr_prio_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .run_i        (run),
        .rf_valid_i   (bus.rf_valid),
        .st_valid_i   (bus.st_valid),
        .starve_cnt_i (starve_cnt_q),
        .rf_ready_o   (rf_ready),
        .st_ready_o   (st_ready),
        .rf_grant_o   (rf_grant),
        .st_grant_o   (st_grant)
    );

    // Counts refill grants taken while a store is waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.st_valid || st_grant) begin
            starve_cnt_d = '0;
        end else if (rf_grant && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    // Address and data hold on idle cycles; only the enables drop to zero.
    always_comb begin
        waddr_d = waddr_q;
        din_d   = din_q;
        we_d    = '0;
        if (rf_grant) begin
            waddr_d = bus.rf_addr;
            din_d   = bus.rf_data;
            we_d    = WE_ALL;
        end else if (st_grant) begin
            waddr_d = bus.st_addr;
            din_d   = bus.st_data;
            we_d    = bus.st_strb;
        end
`ifdef L1_BRAM_CLEAR_EN
        if (clearing) begin
            waddr_d = clr_addr_q;
            din_d   = '0;
            we_d    = WE_ALL;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_q <= '0;
            waddr_q      <= '0;
            din_q        <= '0;
            we_q         <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            waddr_q      <= waddr_d;
            din_q        <= din_d;
            we_q         <= we_d;
        end
    end

    assign bus.rf_ready   = rf_ready;
    assign bus.st_ready   = st_ready;
    assign bus.bram_waddr = waddr_q;
    assign bus.bram_din   = din_q;
    assign bus.bram_we    = we_q;

endmodule

// File: tb/tb_bram_wr_sched.sv
// Self-checking bench for bram_wr_sched against a behavioural write-port model;
// covers both builds of L1_BRAM_CLEAR_EN.
module tb_bram_wr_sched;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SL = 4;
    localparam int SW = DW / 8;
    localparam int VW = 2 + SW + AW + DW + 4;
    localparam logic [SW-1:0] ALL_WE = '1;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: what the BRAM port should show this cycle, plus the store wait count
    int            m_starve;
    logic          m_run;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_din;
    logic [SW-1:0] m_we;

    bram_wr_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_wr_sched #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic exp_rf_ready();
        return m_run && !(bus.st_valid && (m_starve >= SL));
    endfunction

    function automatic logic exp_st_ready();
        return m_run && !(bus.rf_valid && (m_starve < SL));
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.rf_ready, bus.st_ready, bus.bram_we, bus.bram_waddr, bus.bram_din,
                dut.starve_cnt_q};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {exp_rf_ready(), exp_st_ready(), m_we, m_waddr, m_din, 4'(m_starve)};
    endfunction

    // Decide this cycle's winner from the current requests, then cross the edge
    task automatic advance(output logic rf_g, output logic st_g);
        rf_g = bus.rf_valid && exp_rf_ready();
        st_g = bus.st_valid && exp_st_ready();
        if (rf_g) begin
            m_we = ALL_WE; m_waddr = bus.rf_addr; m_din = bus.rf_data;
        end else if (st_g) begin
            m_we = bus.st_strb; m_waddr = bus.st_addr; m_din = bus.st_data;
        end else begin
            m_we = '0;
        end
        if (!bus.st_valid || st_g) m_starve = 0;
        else if (rf_g && m_starve < 15) m_starve = m_starve + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        rstn = 1'b0;
        bus.rf_valid = 1'b0; bus.rf_addr = '0; bus.rf_data = '0;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_strb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.bram_we, bus.bram_waddr, bus.bram_din} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got we=%h waddr=%h din=%h, want 0", bus.bram_we,
                     bus.bram_waddr, bus.bram_din);
        end
        n_cmp++;
`ifdef L1_BRAM_CLEAR_EN
        if (bus.init_done !== 1'b0) begin
`else
        if (bus.init_done !== 1'b1) begin
`endif
            n_bad++;
            $display("FAIL reset_init_done: got %b", bus.init_done);
        end
        n_cmp++;
        if (dut.starve_cnt_q !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_q);
        end
    endtask

`ifdef L1_BRAM_CLEAR_EN
    task automatic test_reset_mid_sweep();
        @(negedge clk);
        rstn = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.bram_we, bus.bram_waddr, bus.bram_din, bus.init_done} !==
            {ALL_WE, 4'd6, 32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_sweep_pre: got we=%h waddr=%0d din=%h init=%b, want we=f waddr=6",
                     bus.bram_we, bus.bram_waddr, bus.bram_din, bus.init_done);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.bram_we, bus.bram_waddr, bus.bram_din, bus.init_done} !== '0) begin
            n_bad++;
            $display("FAIL mid_sweep_async: got we=%h waddr=%0d din=%h init=%b, want all 0",
                     bus.bram_we, bus.bram_waddr, bus.bram_din, bus.init_done);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.bram_we, bus.bram_waddr, bus.bram_din} !== {ALL_WE, 4'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL mid_sweep_restart: got we=%h waddr=%0d, want we=f waddr=0",
                     bus.bram_we, bus.bram_waddr);
        end
        rstn = 1'b0;
        #1;
    endtask

    task automatic test_clear();
        logic g_rf, g_st;
        bus.rf_valid = 1'b1; bus.rf_addr = 4'd9; bus.rf_data = 32'h1234_5678;
        bus.st_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.bram_we, bus.bram_waddr, bus.bram_din, bus.init_done} !==
                {ALL_WE, AW'(k - 1), 32'd0, (k == 16)}) begin
                n_bad++;
                $display("FAIL clear_step %0d: got we=%h waddr=%0d din=%h init=%b", k,
                         bus.bram_we, bus.bram_waddr, bus.bram_din, bus.init_done);
            end
            if (k < 16) begin
                n_cmp++;
                if (bus.rf_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL clear_hold %0d: rf_ready got %b want 0", k, bus.rf_ready);
                end
            end
        end
        m_run = 1'b1; m_starve = 0; m_waddr = 4'd15; m_din = '0; m_we = ALL_WE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear_first_grant %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            advance(g_rf, g_st);
            bus.rf_valid = 1'b0;
        end
    endtask
`else
    task automatic test_release_run();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_run = 1'b1; m_starve = 0; m_waddr = '0; m_din = '0; m_we = '0;
        n_cmp++;
        if (bus.init_done !== 1'b1) begin
            n_bad++;
            $display("FAIL release_init_done: got %b want 1", bus.init_done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic g_rf, g_st;
        bus.rf_valid = 1'b1; bus.rf_addr = 4'd5; bus.rf_data = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL mid_run_pre: got %h want %h", dut_vec(), exp_vec());
        end
        advance(g_rf, g_st);
        bus.rf_valid = 1'b0;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.bram_we, bus.bram_waddr, bus.bram_din} !== '0) begin
            n_bad++;
            $display("FAIL mid_run_async: got we=%h waddr=%0d din=%h, want all 0",
                     bus.bram_we, bus.bram_waddr, bus.bram_din);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_starve = 0; m_waddr = '0; m_din = '0; m_we = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL mid_run_discard: got %h want %h", dut_vec(), exp_vec());
        end
        advance(g_rf, g_st);
    endtask
`endif

    task automatic test_single_store();
        logic g_rf, g_st;
        bus.st_valid = 1'b1; bus.st_addr = 4'd3; bus.st_data = 32'hAABB_CCDD;
        bus.st_strb = 4'b0101;
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL store_accept: got %h want %h", dut_vec(), exp_vec());
        end
        advance(g_rf, g_st);
        bus.st_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.bram_waddr, bus.bram_din, bus.bram_we} !== {4'd3, 32'hAABB_CCDD, 4'b0101}) begin
            n_bad++;
            $display("FAIL store_write: got waddr=%0d din=%h we=%b want 3 aabbccdd 0101",
                     bus.bram_waddr, bus.bram_din, bus.bram_we);
        end
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL store_model: got %h want %h", dut_vec(), exp_vec());
        end
        advance(g_rf, g_st);
    endtask

    task automatic test_refill_only();
        logic g_rf, g_st;
        int   writes = 0;
        bus.st_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.rf_valid = (i < 8);
            bus.rf_addr  = AW'($urandom);
            bus.rf_data  = $urandom;
            @(negedge clk);
            if (bus.bram_we === ALL_WE) writes++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL refill_only %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            advance(g_rf, g_st);
        end
        n_cmp++;
        if (writes != 8) begin
            n_bad++;
            $display("FAIL refill_count: got %0d full-word writes want 8", writes);
        end
    endtask

    task automatic test_contention();
        logic g_rf, g_st;
        int   exp_cnt[6] = '{0, 1, 2, 3, 4, 0};
        logic exp_st[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.rf_valid = 1'b1; bus.rf_addr = AW'($urandom); bus.rf_data = $urandom;
        bus.st_valid = 1'b1; bus.st_addr = AW'($urandom); bus.st_data = $urandom;
        bus.st_strb  = SW'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({dut.starve_cnt_q, bus.st_ready, bus.rf_ready} !==
                {4'(exp_cnt[i]), exp_st[i], !exp_st[i]}) begin
                n_bad++;
                $display("FAIL contention %0d: got cnt=%0d st_rdy=%b rf_rdy=%b want cnt=%0d st_rdy=%b",
                         i, dut.starve_cnt_q, bus.st_ready, bus.rf_ready, exp_cnt[i], exp_st[i]);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL contention_model %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            advance(g_rf, g_st);
            if (g_rf) begin bus.rf_addr = AW'($urandom); bus.rf_data = $urandom; end
            if (g_st) begin bus.st_addr = AW'($urandom); bus.st_data = $urandom; end
        end
        bus.rf_valid = 1'b0;
        bus.st_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL contention_tail: got %h want %h", dut_vec(), exp_vec());
        end
        advance(g_rf, g_st);
    endtask

    task automatic test_random();
        logic g_rf, g_st;
        bus.rf_valid = 1'b0;
        bus.st_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            advance(g_rf, g_st);
            if (!bus.rf_valid || g_rf) begin
                bus.rf_valid = ($urandom_range(0, 99) < 60);
                bus.rf_addr  = AW'($urandom);
                bus.rf_data  = $urandom;
            end
            if (!bus.st_valid || g_st) begin
                bus.st_valid = ($urandom_range(0, 99) < 50);
                bus.st_addr  = AW'($urandom);
                bus.st_data  = $urandom;
                bus.st_strb  = SW'($urandom);
            end
        end
    endtask

    initial begin
        m_run = 1'b0; m_starve = 0; m_waddr = '0; m_din = '0; m_we = '0;
        test_reset();
`ifdef L1_BRAM_CLEAR_EN
        test_reset_mid_sweep();
        test_clear();
`else
        test_release_run();
`endif
        test_single_store();
        test_refill_only();
        test_contention();
`ifndef L1_BRAM_CLEAR_EN
        test_reset_mid_run();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_wr_sched.md
# bram_wr_sched

Write-port scheduler for the L1 cache byte-write block RAMs. It arbitrates the single BRAM write port between the refill path, which writes full words, and the store path, which writes byte-masked words. Refill has priority, and a starvation limit guarantees store progress. When compiled with the clear feature, it sweeps the whole array to zero after reset before accepting any request. It sits between the L1 control logic and the write side (waddr/din/we) of a bytewrite BRAM instance.

## Interface
Parameters:
- DATA_WIDTH, 32, BRAM word width; must be a multiple of 8.
- ADDR_WIDTH, 8, BRAM address width; depth = 2^ADDR_WIDTH.
- STARVE_LIMIT, 4, consecutive refill grants allowed while a store waits; range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset; asynchronous, active-low.
- rf_valid  in  1  refill request.
- rf_ready  out  1  refill accepted this cycle when rf_valid && rf_ready.
- rf_addr  in  ADDR_WIDTH  refill word address.
- rf_data  in  DATA_WIDTH  refill word; written with all byte enables set.
- st_valid  in  1  store request.
- st_ready  out  1  store accepted this cycle when st_valid && st_ready.
- st_addr  in  ADDR_WIDTH  store word address.
- st_data  in  DATA_WIDTH  store data.
- st_strb  in  DATA_WIDTH/8  store byte enables.
- bram_waddr  out  ADDR_WIDTH  registered BRAM write address.
- bram_din  out  DATA_WIDTH  registered BRAM write data.
- bram_we  out  DATA_WIDTH/8  registered BRAM byte write enables.
- init_done  out  1  high once the scheduler accepts requests.

## Operation
- States: CLEAR and RUN.
- CLEAR exists only with the macro defined; without it the block sits permanently in RUN.
- CLEAR:
  - The address counter clr_addr steps 0 → 2^ADDR_WIDTH−1, one word per cycle.
  - Each step drives bram_waddr=clr_addr, bram_din=0, bram_we=all ones.
  - rf_ready=st_ready=0.
  - After the last address is issued, the block moves to RUN and sets init_done=1.
  - Requests arriving during CLEAR are held by their sources, never dropped.
- RUN, grant rules:
  - rf_ready = !st_valid || starve_cnt < STARVE_LIMIT.
  - st_ready = !rf_valid || starve_cnt == STARVE_LIMIT.
  - At most one grant per cycle; ready does not depend on the requester's own valid.
- starve_cnt, width 4, saturating:
  - Increments on a refill grant while st_valid is high.
  - Clears on a store grant, or on any cycle st_valid is low.
- Granted request: registered onto the BRAM port next cycle.
  - Refill: we = all ones.
  - Store: we = st_strb.
- No grant: bram_we = 0; bram_waddr and bram_din hold their last value.
- A store with st_strb=0 is still granted and consumes a slot, issuing we=0.
- Requesters must hold valid and payload stable until accepted.

## Timing
- Reset values: bram_we=0, bram_waddr=0, bram_din=0, starve_cnt=0.
  - Macro defined: state=CLEAR, clr_addr=0, init_done=0.
  - Macro not defined: state=RUN, init_done=1.
- Latency: handshake in cycle N → BRAM write presented in cycle N+1 and committed at the N+1→N+2 edge.
- Throughput: one write per cycle.
- Clear duration: exactly 2^ADDR_WIDTH cycles after rstn deasserts. The first RUN grant is possible in the cycle init_done first reads 1.
- clr_addr wraps to 0 when the sweep completes; no extra write is issued.
- Reset asserted mid-operation or mid-sweep:
  - All outputs return to their reset values asynchronously.
  - Any in-flight registered write is discarded.
  - The sweep restarts from address 0.
- Both valid with starve_cnt < STARVE_LIMIT: refill wins.
- Both valid with starve_cnt == STARVE_LIMIT: store wins, and starve_cnt clears.

## Configuration
- L1_BRAM_CLEAR_EN defined:
  - CLEAR state, clr_addr counter and the zero sweep are compiled in.
  - init_done rises after 2^ADDR_WIDTH cycles.
- L1_BRAM_CLEAR_EN not defined:
  - No counter, no sweep; the block starts in RUN.
  - init_done is tied to 1; the BRAM holds its power-up contents.

## Structure
- Shared package l1_cache_pkg:
  - state typedef (CLEAR, RUN).
  - starvation counter width constant (4).
  - the DATA_WIDTH/8 strobe-width helper.
- One sub-module, bram_wr_prio_arb:
  - Purely combinational grant logic from rf_valid, st_valid and starve_cnt.
  - The counter and output registers stay in bram_wr_sched.

## Test plan
- Clear sweep, macro defined, ADDR_WIDTH=4: release rstn → 16 cycles of we=4'hF, din=0, waddr 0..15 → init_done=1 on cycle 16, then bram_we=0 while idle.
- Single store: st_addr=3, st_data=32'hAABBCCDD, st_strb=4'b0101 → next cycle waddr=3, din=32'hAABBCCDD, we=4'b0101.
- Contention, STARVE_LIMIT=4: rf_valid and st_valid held high → refill granted 4 cycles, store granted on the 5th, then refill again; starve_cnt observed 0,1,2,3,4,0.
- Refill only: rf_valid high for 8 cycles with st_valid low → 8 back-to-back writes with we=4'hF, starve_cnt stays 0.
- Reset mid-sweep: assert rstn low at clr_addr=7 → outputs zero immediately; after release the sweep restarts at waddr=0.
- Macro not defined: init_done=1 out of reset, and a store on the first cycle after reset is accepted.
